// File: rtl/turf_reg_pkg.sv
// Shared types and constants for the TURF-side register link responder.
package turf_reg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_DATA,
    ST_WR_COMMIT,
    ST_RD_ISSUE,
    ST_RD_TURN,
    ST_RD_DATA,
    ST_HOLD
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int RD_TURN_CYCLES = 1;

  localparam int HDR_BANK_MSB = 7;
  localparam int HDR_BANK_LSB = 6;
  localparam int HDR_ADDR_MSB = 5;
  localparam int HDR_ADDR_LSB = 0;

  function automatic logic [7:0] hdr_to_addr(input logic [7:0] hdr);
    return {hdr[HDR_BANK_MSB:HDR_BANK_LSB], hdr[HDR_ADDR_MSB:HDR_ADDR_LSB]};
  endfunction

endpackage

// File: rtl/turf_word_shifter.sv
// 4-byte word shifter: deserializes write bytes LSB first and serializes read
// words LSB first, with a 2-bit byte index shared by both directions.
module turf_word_shifter
  import turf_reg_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        clr,
  input  logic        load,
  input  logic        shift,
  input  logic [7:0]  din,
  input  logic [31:0] load_word,
  output logic [7:0]  byte_o,
  output logic [31:0] shifted_o,
  output logic [1:0]  idx_o
);

  logic [8*BYTES_PER_WORD-1:0] word;

  // New bytes enter at the top so the first byte ends up in the LSB.
  assign shifted_o = {din, word[31:8]};
  assign byte_o    = word[7:0];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      word  <= '0;
      idx_o <= '0;
    end else if (load) begin
      word  <= load_word;
      idx_o <= '0;
    end else if (shift) begin
      word  <= shifted_o;
      idx_o <= idx_o + 2'd1;
    end else if (clr) begin
      idx_o <= '0;
    end
  end

endmodule

// File: rtl/turf_register_responder.sv
// TURF-side responder of the byte-serial register link: decodes nCS-framed
// header/data bytes into single-cycle strobes on a local 32-bit register port.
//
// state        | meaning
// ST_IDLE      | waiting for a frame; header sampled on first ncs_i=0 cycle
// ST_WR_DATA   | collecting four write bytes, LSB first
// ST_WR_COMMIT | reg_wr_o high, full word on reg_dat_o
// ST_RD_ISSUE  | reg_rd_o high
// ST_RD_TURN   | bus turnaround, read data captured at the end
// ST_RD_DATA   | driving four read bytes, LSB first
// ST_HOLD      | frame done, waiting for ncs_i=1
module turf_register_responder
  import turf_reg_pkg::*;
#(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 ncs_i,
  input  logic                 wnr_i,
  input  logic [7:0]           dio_i,
  output logic [7:0]           dio_o,
  output logic                 dio_oe_o,
  output logic [7:0]           reg_addr_o,
  output logic [31:0]          reg_dat_o,
  output logic                 reg_wr_o,
  output logic                 reg_rd_o,
  input  logic [31:0]          reg_dat_i,
  output logic [CNT_WIDTH-1:0] abort_cnt_o
);

  localparam logic [1:0] LAST_IDX  = 2'(BYTES_PER_WORD - 1);
  localparam logic [1:0] TURN_LOAD = 2'(RD_TURN_CYCLES - 1);

  state_t      state, state_nxt;
  logic [1:0]  turn_cnt;
  logic [1:0]  idx;
  logic [31:0] shifted;
  logic        sh_clr, sh_load, sh_shift;
  logic        addr_ld, wr_set, rd_set, turn_ld, abort, oe_nxt;

  turf_word_shifter u_shifter (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .clr       (sh_clr),
    .load      (sh_load),
    .shift     (sh_shift),
    .din       (dio_i),
    .load_word (reg_dat_i),
    .byte_o    (dio_o),
    .shifted_o (shifted),
    .idx_o     (idx)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sh_clr    = 1'b0;
    sh_load   = 1'b0;
    sh_shift  = 1'b0;
    addr_ld   = 1'b0;
    wr_set    = 1'b0;
    rd_set    = 1'b0;
    turn_ld   = 1'b0;
    abort     = 1'b0;
    oe_nxt    = dio_oe_o;
    case (state)
      ST_IDLE: begin
        if (!ncs_i) begin
          addr_ld   = 1'b1;
          sh_clr    = 1'b1;
          rd_set    = !wnr_i;
          state_nxt = wnr_i ? ST_WR_DATA : ST_RD_ISSUE;
        end
      end
      ST_WR_DATA: begin
        if (ncs_i) begin
          abort     = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          sh_shift = 1'b1;
          if (idx == LAST_IDX) begin
            wr_set    = 1'b1;
            state_nxt = ST_WR_COMMIT;
          end
        end
      end
      // The strobe is already out; a frame ending here is complete, not aborted.
      ST_WR_COMMIT: state_nxt = ncs_i ? ST_IDLE : ST_HOLD;
      ST_RD_ISSUE: begin
        if (ncs_i) begin
          abort     = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          turn_ld   = 1'b1;
          state_nxt = ST_RD_TURN;
        end
      end
      ST_RD_TURN: begin
        if (ncs_i) begin
          abort     = 1'b1;
          state_nxt = ST_IDLE;
        end else if (turn_cnt == '0) begin
          sh_load   = 1'b1;
          oe_nxt    = 1'b1;
          state_nxt = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        if (ncs_i) begin
          abort     = 1'b1;
          state_nxt = ST_IDLE;
        end else if (idx == LAST_IDX) begin
          oe_nxt    = 1'b0;
          state_nxt = ST_HOLD;
        end else begin
          sh_shift = 1'b1;
        end
      end
      ST_HOLD: if (ncs_i) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (abort) oe_nxt = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      turn_cnt    <= '0;
      dio_oe_o    <= 1'b0;
      reg_addr_o  <= '0;
      reg_dat_o   <= '0;
      reg_wr_o    <= 1'b0;
      reg_rd_o    <= 1'b0;
      abort_cnt_o <= '0;
    end else begin
      reg_wr_o <= wr_set;
      reg_rd_o <= rd_set;
      dio_oe_o <= oe_nxt;
      if (turn_ld)                               turn_cnt <= TURN_LOAD;
      else if (state == ST_RD_TURN && turn_cnt != '0) turn_cnt <= turn_cnt - 2'd1;
      if (addr_ld) reg_addr_o <= hdr_to_addr(dio_i);
      if (wr_set)  reg_dat_o  <= shifted;
      if (abort && abort_cnt_o != {CNT_WIDTH{1'b1}})
        abort_cnt_o <= abort_cnt_o + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_turf_register_responder.sv
// Directed self-checking bench for turf_register_responder.
module tb_turf_register_responder;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        ncs_i = 1'b1;
  logic        wnr_i = 1'b0;
  logic [7:0]  dio_i = '0;
  logic [7:0]  dio_o;
  logic        dio_oe_o;
  logic [7:0]  reg_addr_o;
  logic [31:0] reg_dat_o;
  logic        reg_wr_o;
  logic        reg_rd_o;
  logic [31:0] reg_dat_i = '0;
  logic [7:0]  abort_cnt_o;

  int total = 0;
  int bad = 0;
  int exp_abort = 0;

  turf_register_responder #(.CNT_WIDTH(8)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .ncs_i       (ncs_i),
    .wnr_i       (wnr_i),
    .dio_i       (dio_i),
    .dio_o       (dio_o),
    .dio_oe_o    (dio_oe_o),
    .reg_addr_o  (reg_addr_o),
    .reg_dat_o   (reg_dat_o),
    .reg_wr_o    (reg_wr_o),
    .reg_rd_o    (reg_rd_o),
    .reg_dat_i   (reg_dat_i),
    .abort_cnt_o (abort_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Drive one cycle's inputs, then advance to 1 time unit after the next edge.
  task automatic step(input logic ncs, input logic wnr, input logic [7:0] dio,
                      input logic [31:0] rdat);
    ncs_i = ncs; wnr_i = wnr; dio_i = dio; reg_dat_i = rdat;
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset;
    total++; if (dio_oe_o !== 1'b0) begin bad++; $display("FAIL rst_oe got=%b exp=0", dio_oe_o); end
    total++; if (dio_o !== 8'h00) begin bad++; $display("FAIL rst_dio got=%h exp=00", dio_o); end
    total++; if (reg_addr_o !== 8'h00) begin bad++; $display("FAIL rst_addr got=%h exp=00", reg_addr_o); end
    total++; if (reg_dat_o !== 32'h0) begin bad++; $display("FAIL rst_dat got=%h exp=0", reg_dat_o); end
    total++; if ({reg_wr_o, reg_rd_o} !== 2'b00) begin bad++; $display("FAIL rst_strobes got=%b exp=00", {reg_wr_o, reg_rd_o}); end
    total++; if (abort_cnt_o !== 8'h00) begin bad++; $display("FAIL rst_abort got=%h exp=00", abort_cnt_o); end
  endtask

  task automatic test_write;
    logic [7:0] v [5];
    v = '{8'h88, 8'h67, 8'h45, 8'h23, 8'h01};
    for (int c = 0; c <= 7; c++) begin
      if (c >= 1) begin
        total++; if (reg_wr_o !== (c == 5)) begin bad++; $display("FAIL wr_strobe c=%0d got=%b exp=%b", c, reg_wr_o, (c == 5)); end
        total++; if (dio_oe_o !== 1'b0) begin bad++; $display("FAIL wr_oe c=%0d got=%b exp=0", c, dio_oe_o); end
        if (c <= 5) begin
          total++; if (reg_addr_o !== 8'h88) begin bad++; $display("FAIL wr_addr c=%0d got=%h exp=88", c, reg_addr_o); end
        end
        if (c >= 5) begin
          total++; if (reg_dat_o !== 32'h01234567) begin bad++; $display("FAIL wr_data c=%0d got=%h exp=01234567", c, reg_dat_o); end
        end
      end
      if (c <= 4) step(1'b0, 1'b1, v[c], 32'h0);
      else        step(1'b1, 1'b0, 8'h00, 32'h0);
    end
  endtask

  task automatic test_read;
    logic [7:0] rb [4];
    rb = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    for (int c = 0; c <= 8; c++) begin
      if (c >= 1) begin
        total++; if (reg_rd_o !== (c == 1)) begin bad++; $display("FAIL rd_strobe c=%0d got=%b exp=%b", c, reg_rd_o, (c == 1)); end
        total++; if (dio_oe_o !== (c >= 3 && c <= 6)) begin bad++; $display("FAIL rd_oe c=%0d got=%b exp=%b", c, dio_oe_o, (c >= 3 && c <= 6)); end
        if (c >= 3 && c <= 6) begin
          total++; if (dio_o !== rb[c-3]) begin bad++; $display("FAIL rd_byte c=%0d got=%h exp=%h", c, dio_o, rb[c-3]); end
        end
        total++; if (reg_wr_o !== 1'b0) begin bad++; $display("FAIL rd_no_wr c=%0d got=%b exp=0", c, reg_wr_o); end
      end
      if (c <= 6) step(1'b0, 1'b0, 8'h00, (c == 2) ? 32'hDEADBEEF : 32'h0);
      else        step(1'b1, 1'b0, 8'h00, 32'h0);
    end
  endtask

  task automatic test_write_abort;
    logic [7:0] v [5];
    v = '{8'h41, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
    step(1'b0, 1'b1, 8'h10, 32'h0);
    step(1'b0, 1'b1, 8'h11, 32'h0);
    step(1'b0, 1'b1, 8'h22, 32'h0);
    for (int c = 3; c <= 5; c++) begin
      total++; if (reg_wr_o !== 1'b0) begin bad++; $display("FAIL wab_no_wr c=%0d got=%b exp=0", c, reg_wr_o); end
      step(1'b1, 1'b0, 8'h00, 32'h0);
    end
    exp_abort++;
    total++; if (abort_cnt_o !== 8'(exp_abort)) begin bad++; $display("FAIL wab_cnt got=%0d exp=%0d", abort_cnt_o, exp_abort); end
    total++; if (reg_dat_o !== 32'h01234567) begin bad++; $display("FAIL wab_dat_kept got=%h exp=01234567", reg_dat_o); end
    for (int c = 0; c <= 6; c++) begin
      if (c >= 1) begin
        total++; if (reg_wr_o !== (c == 5)) begin bad++; $display("FAIL wab_next_wr c=%0d got=%b exp=%b", c, reg_wr_o, (c == 5)); end
      end
      if (c == 5) begin
        total++; if (reg_addr_o !== 8'h41) begin bad++; $display("FAIL wab_next_addr got=%h exp=41", reg_addr_o); end
        total++; if (reg_dat_o !== 32'hA5A5A5A5) begin bad++; $display("FAIL wab_next_dat got=%h exp=A5A5A5A5", reg_dat_o); end
      end
      if (c <= 4) step(1'b0, 1'b1, v[c], 32'h0);
      else        step(1'b1, 1'b0, 8'h00, 32'h0);
    end
  endtask

  // Read cut short in cycle 4; a write header in cycle 5 proves the FSM is idle.
  task automatic test_read_abort;
    logic [7:0] v [5];
    v = '{8'h07, 8'h44, 8'h33, 8'h22, 8'h11};
    for (int c = 0; c <= 11; c++) begin
      if (c == 4) begin
        total++; if (dio_oe_o !== 1'b1) begin bad++; $display("FAIL rab_oe_before got=%b exp=1", dio_oe_o); end
      end
      if (c == 5) begin
        total++; if (dio_oe_o !== 1'b0) begin bad++; $display("FAIL rab_oe_after got=%b exp=0", dio_oe_o); end
        exp_abort++;
        total++; if (abort_cnt_o !== 8'(exp_abort)) begin bad++; $display("FAIL rab_cnt got=%0d exp=%0d", abort_cnt_o, exp_abort); end
      end
      if (c == 10) begin
        total++; if (reg_wr_o !== 1'b1) begin bad++; $display("FAIL rab_idle_wr got=%b exp=1", reg_wr_o); end
        total++; if (reg_dat_o !== 32'h11223344) begin bad++; $display("FAIL rab_idle_dat got=%h exp=11223344", reg_dat_o); end
      end
      if (c <= 3)       step(1'b0, 1'b0, 8'h05, (c == 2) ? 32'h12345678 : 32'h0);
      else if (c == 4)  step(1'b1, 1'b0, 8'h00, 32'h0);
      else if (c <= 9)  step(1'b0, 1'b1, v[c-5], 32'h0);
      else              step(1'b1, 1'b0, 8'h00, 32'h0);
    end
  endtask

  task automatic test_async_reset;
    logic [7:0] v [4];
    v = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int c = 0; c <= 3; c++) step(1'b0, 1'b0, 8'h00, (c == 2) ? 32'hCAFEF00D : 32'h0);
    total++; if (dio_oe_o !== 1'b1) begin bad++; $display("FAIL ars_oe_pre got=%b exp=1", dio_oe_o); end
    ncs_i = 1'b0; wnr_i = 1'b1; dio_i = 8'h3C;
    #2 rst_n_i = 1'b0;
    #1;
    total++; if (dio_oe_o !== 1'b0) begin bad++; $display("FAIL ars_oe_async got=%b exp=0", dio_oe_o); end
    total++; if (dio_o !== 8'h00) begin bad++; $display("FAIL ars_dio got=%h exp=00", dio_o); end
    total++; if (reg_addr_o !== 8'h00 || reg_dat_o !== 32'h0) begin bad++; $display("FAIL ars_regs got=%h/%h exp=00/0", reg_addr_o, reg_dat_o); end
    total++; if (abort_cnt_o !== 8'h00) begin bad++; $display("FAIL ars_abort got=%h exp=00", abort_cnt_o); end
    exp_abort = 0;
    #2 rst_n_i = 1'b1;
    @(posedge clk_i); #1;
    for (int c = 1; c <= 6; c++) begin
      if (c == 5) begin
        total++; if (reg_wr_o !== 1'b1) begin bad++; $display("FAIL ars_rel_wr got=%b exp=1", reg_wr_o); end
        total++; if (reg_addr_o !== 8'h3C || reg_dat_o !== 32'h44332211) begin bad++; $display("FAIL ars_rel_word got=%h/%h exp=3C/44332211", reg_addr_o, reg_dat_o); end
      end
      if (c <= 4) step(1'b0, 1'b1, v[c-1], 32'h0);
      else        step(1'b1, 1'b0, 8'h00, 32'h0);
    end
  endtask

  task automatic test_frame_extension;
    int wr_seen;
    wr_seen = 0;
    for (int c = 0; c <= 16; c++) begin
      if (reg_wr_o === 1'b1) wr_seen++;
      if (c <= 14) step(1'b0, 1'b1, 8'(8'h50 + c), 32'h0);
      else         step(1'b1, 1'b1, 8'hFF, 32'h0);
    end
    total++; if (wr_seen != 1) begin bad++; $display("FAIL ext_wr_count got=%0d exp=1", wr_seen); end
    total++; if (reg_dat_o !== 32'h54535251) begin bad++; $display("FAIL ext_dat got=%h exp=54535251", reg_dat_o); end
    total++; if (abort_cnt_o !== 8'(exp_abort)) begin bad++; $display("FAIL ext_abort got=%0d exp=%0d", abort_cnt_o, exp_abort); end
  endtask

  task automatic test_saturation;
    for (int f = 0; f < 260; f++) begin
      step(1'b0, 1'b1, 8'h01, 32'h0);
      step(1'b1, 1'b0, 8'h00, 32'h0);
      if (exp_abort < 255) exp_abort++;
      if (f == 9) begin
        total++; if (abort_cnt_o !== 8'(exp_abort)) begin bad++; $display("FAIL sat_mid got=%0d exp=%0d", abort_cnt_o, exp_abort); end
      end
    end
    total++; if (abort_cnt_o !== 8'hFF) begin bad++; $display("FAIL sat_final got=%h exp=FF", abort_cnt_o); end
    total++; if (reg_wr_o !== 1'b0) begin bad++; $display("FAIL sat_no_wr got=%b exp=0", reg_wr_o); end
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    #3 rst_n_i = 1'b1;
    @(posedge clk_i); #1;
    test_reset();
    test_write();
    test_read();
    test_write_abort();
    test_read_abort();
    test_async_reset();
    test_frame_extension();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
